mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-ported RAM between instruction fetch (icuREN) and data access (dcuREN/dcuWEN) from the pipeline.
//  Sits between the control/datapath request signals and the RAM model; stalls the losing requester.
//  Data has priority; a starvation limit guarantees fetch progress. After halt, fetch grants stop and data still drains.
// PARAMETERS
//  STARVE_LIM  4   consecutive data grants with fetch pending before one fetch grant is forced (1..15)
//  CNT_W       16  width of the perf counters (MEM_ARB_PERF_EN only)
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      synchronous reset, active-high
//  halt      in   1      pipeline halt; level, sampled each cycle
//  iREN      in   1      fetch request; held until iwait low
//  iaddr     in   32     fetch word address
//  dREN      in   1      data load request; held until dwait low
//  dWEN      in   1      data store request; dREN&dWEN together = store
//  daddr     in   32     data address
//  dstore    in   32     store data
//  iwait     out  1      fetch stalled; low exactly in the completion cycle
//  dwait     out  1      data stalled; low exactly in the completion cycle
//  iload     out  32     fetched instruction, valid while iwait low
//  dload     out  32     loaded word, valid while dwait low
//  ramREN    out  1      RAM read strobe
//  ramWEN    out  1      RAM write strobe
//  ramaddr   out  32     RAM address
//  ramstore  out  32     RAM write data
//  ramload   in   32     RAM read data
//  ramstate  in   2      ramstate_t: FREE, BUSY, ACCESS, ERROR
//  memerr    out  1      sticky; set on ERROR completion, cleared only by RST
//  icnt_o    out  CNT_W  fetch stall cycles (0 when macro off)
//  dcnt_o    out  CNT_W  data stall cycles (0 when macro off)
// BEHAVIOUR
//  FSM arb_state_t: ARB, IGNT, DGNT. Reset: ARB, streak=0, memerr=0, counters=0.
//  Output reset values: iwait=1, dwait=1, ram strobes=0, ramaddr/ramstore=0, iload/dload=0.
//  ARB: no RAM strobes. Next state is chosen by this priority:
//   (1) DGNT if (dREN|dWEN) and not (iREN & !halt & streak==STARVE_LIM);
//   (2) IGNT if iREN & !halt;
//   (3) otherwise stay in ARB.
//  IGNT: ramREN=1, ramaddr=iaddr. DGNT: ramREN=dREN&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
//  The granted state holds while ramstate is BUSY or FREE.
//  On ACCESS or ERROR in the granted state:
//   - the granted wait output goes low for that one cycle; iload/dload = ramload; next state is ARB.
//  ERROR additionally sets memerr; the loaded data is don't-care.
//  Minimum latency: request at cycle 0 -> grant at cycle 1 -> wait low at cycle 1 if the RAM returns ACCESS the same cycle.
//  Back-to-back grants therefore cost 1 ARB cycle.
//  streak: +1 (saturating at STARVE_LIM) on each data completion while iREN & !halt; cleared on fetch completion.
//  Also cleared on any data completion with no fetch pending.
//  Requests are not re-sampled mid-grant. A requester dropping its request mid-grant is illegal (assertion).
//  halt rising during IGNT: the fetch completes normally; no fetch is granted afterwards.
//  RST mid-grant: return to ARB next cycle, strobes drop the same edge, and the transaction is abandoned.
//  Wait outputs are combinational from state+ramstate; all other state is registered.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: icnt_o +1 each cycle iREN&iwait&!halt; dcnt_o +1 each cycle (dREN|dWEN)&dwait.
//   Both counters saturate at all-ones and are cleared by RST.
//  MEM_ARB_PERF_EN undefined: counter registers removed; icnt_o/dcnt_o tied to 0; ports stay present.
// STRUCTURE
//  cpu_types_pkg: add arb_state_t (ARB/IGNT/DGNT); reuse word_t and ramstate_t.
//  No sub-module; the counters are inline generate/ifdef logic.
// TESTING
//  iREN only, iaddr=0x40, RAM returns ACCESS after 2 BUSY -> ramREN for 3 cycles; iwait low on cycle 3 with iload=ramload.
//  iREN+dWEN together, daddr=0x80, dstore=0xDEADBEEF -> data is served first with ramWEN=1; fetch is granted after one ARB cycle.
//  Data held continuously with iREN held, STARVE_LIM=4 -> exactly 4 data completions, then 1 fetch, then data resumes.
//  halt=1 with iREN held, no data -> stays in ARB with iwait=1 indefinitely; dREN still completes.
//  ramstate=ERROR on a dREN grant -> dwait low for 1 cycle, memerr=1 and stays set; RST clears it to 0.
//  RST asserted during DGNT -> next cycle ARB, ramWEN=0, dwait=1; with the macro on, counters read 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM handshake status (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : memory arbiter FSM state (ARB, IGNT, DGNT)
//   ram_done()  : true when the RAM finishes the current access (ACCESS or ERROR)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  // Wide enough for any starvation limit in 1..15.
  localparam int STREAK_W = 4;

  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported RAM between instruction fetch and
// data access. Data wins arbitration; after STARVE_LIM consecutive data
// completions with a fetch pending, one fetch grant is forced. While halt is
// high no fetch is granted, but data requests still drain.
//
// Handshake: a requester raises iREN (or dREN/dWEN) and holds it, with its
// address/data stable, until its wait output is seen low. The wait output is
// low for exactly the completion cycle, and iload/dload carry ramload in that
// same cycle. Dropping a request while it is granted is illegal.
//
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   halt               pipeline halt level, blocks new fetch grants
//   iREN, iaddr        fetch request and word address
//   dREN, dWEN, daddr  data request (dWEN set = store), address
//   dstore             store data
//   iwait, dwait       stall outputs, low in the completion cycle
//   iload, dload       returned read data, valid while the wait is low
//   ramREN, ramWEN     RAM strobes; ramaddr, ramstore to the RAM
//   ramload, ramstate  RAM read data and status
//   memerr             sticky error flag, cleared only by RST
//   icnt_o, dcnt_o     fetch/data stall cycle counters
//   dbg_state          current FSM state
//
// Configuration: define MEM_ARB_PERF_EN to build the saturating stall
// counters; otherwise icnt_o/dcnt_o are tied to zero.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             iREN,
  input  logic [31:0]      iaddr,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             iwait,
  output logic             dwait,
  output logic [31:0]      iload,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate,
  output logic             memerr,
  output logic [CNT_W-1:0] icnt_o,
  output logic [CNT_W-1:0] dcnt_o,
  output arb_state_t       dbg_state
);

  localparam logic [STREAK_W-1:0] LIM = STREAK_W'(STARVE_LIM);

  arb_state_t          state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                memerr_nxt;

  logic fetch_pend;
  logic data_req;
  logic done;

  assign fetch_pend = iREN & ~halt;
  assign data_req   = dREN | dWEN;
  assign done       = ram_done(ramstate);
  assign dbg_state  = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB;
      streak <= '0;
      memerr <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      memerr <= memerr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    memerr_nxt = memerr;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    unique case (state)
      ARB: begin
        // Data wins unless the fetch has waited out the starvation limit.
        if (data_req && !(fetch_pend && streak == LIM)) begin
          state_nxt = DGNT;
        end else if (fetch_pend) begin
          state_nxt = IGNT;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (done) begin
          iwait      = 1'b0;
          iload      = ramload;
          state_nxt  = ARB;
          streak_nxt = '0;
          if (ramstate == ERROR) memerr_nxt = 1'b1;
        end
      end
      DGNT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (done) begin
          dwait     = 1'b0;
          dload     = ramload;
          state_nxt = ARB;
          // Streak counts data wins only while a fetch is actually waiting.
          if (fetch_pend) begin
            streak_nxt = (streak >= LIM) ? LIM : streak + 1'b1;
          end else begin
            streak_nxt = '0;
          end
          if (ramstate == ERROR) memerr_nxt = 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // A granted requester must hold its request until completion.
  a_fetch_held: assert property (@(posedge CLK) disable iff (RST)
    (state == IGNT) |-> iREN);
  a_data_held: assert property (@(posedge CLK) disable iff (RST)
    (state == DGNT) |-> (dREN || dWEN));

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] icnt;
  logic [CNT_W-1:0] dcnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (iREN && iwait && !halt && (icnt != '1)) icnt <= icnt + 1'b1;
      if (data_req && dwait && (dcnt != '1))      dcnt <= dcnt + 1'b1;
    end
  end

  assign icnt_o = icnt;
  assign dcnt_o = dcnt;
`else
  assign icnt_o = '0;
  assign dcnt_o = '0;
`endif

endmodule
